systolic_feeder_2x2: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/feeder_operand_bank.sv | 61 ++++++
 rtl/systolic_feeder_2x2.sv | 178 +++++++++++++++++
 tb/tb_systolic_feeder_2x2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared encodings for the 2x2 systolic array feeder: FSM states,
// operand-bank select values and the array start/reset bus patterns.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } load_sel_t;

    localparam logic [7:0] ARR_START_ALL = 8'h0F;
    localparam logic [7:0] ARR_RESET_ALL = 8'hFF;

endpackage

// File: rtl/feeder_operand_bank.sv
// Operand storage for the feeder: a 2xK A matrix and a Kx2 B matrix, one write
// port, and four combinational skewed read ports selected by the stream step.
module feeder_operand_bank
    import systolic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int K      = 2,
    parameter int ADDR_W = $clog2(2*K),
    parameter int STEP_W = $clog2(K+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  west0,
    output logic [WIDTH-1:0]  west1,
    output logic [WIDTH-1:0]  north0,
    output logic [WIDTH-1:0]  north1
);

    // A entry = row*K + k, B entry = k*2 + col.
    logic [WIDTH-1:0] a_mem [2*K];
    logic [WIDTH-1:0] b_mem [2*K];
    int               s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2*K; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < 2*K)) begin
            if (load_sel_t'(wr_sel) == SEL_A) begin
                a_mem[wr_addr] <= wr_data;
            end else begin
                b_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Row/column 1 lag row/column 0 by one step; anything outside 0..K-1 reads as 0.
    always_comb begin
        s      = int'(step);
        west0  = '0;
        west1  = '0;
        north0 = '0;
        north1 = '0;
        if (s < K) begin
            west0  = a_mem[ADDR_W'(s)];
            north0 = b_mem[ADDR_W'(2*s)];
        end
        if ((s >= 1) && (s <= K)) begin
            west1  = a_mem[ADDR_W'(K + s - 1)];
            north1 = b_mem[ADDR_W'(2*(s-1) + 1)];
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for systolic_array_2x2: clear, skewed stream, drain, done.
// Define FEEDER_TIMEOUT_EN to add the DRAIN watchdog and the sticky err flag.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int K       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   load_sel,
    input  logic [$clog2(2*K)-1:0] load_addr,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   go,
    output logic                   busy,
    output logic                   job_done,
    output logic                   err,
    input  logic                   arr_done,
    output logic [WIDTH-1:0]       west0,
    output logic [WIDTH-1:0]       west1,
    output logic [WIDTH-1:0]       north0,
    output logic [WIDTH-1:0]       north1,
    output logic [7:0]             arr_start,
    output logic [7:0]             arr_reset
);

    localparam int ADDR_W = $clog2(2*K);
    localparam int STEP_W = $clog2(K+1);

    feeder_state_t     state, state_nx;
    logic [STEP_W-1:0] step, step_nx;
    logic              feed_nx;
    logic              job_done_nx;
    logic [7:0]        arr_start_nx;
    logic [7:0]        arr_reset_nx;
    logic [WIDTH-1:0]  bank_w0, bank_w1, bank_n0, bank_n1;

`ifdef FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nx;
    logic             err_nx;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err            = 1'b0;
`endif

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    feeder_operand_bank #(
        .WIDTH  (WIDTH),
        .K      (K),
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load_valid && (state == ST_IDLE)),
        .wr_sel  (load_sel),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .step    (step_nx),
        .west0   (bank_w0),
        .west1   (bank_w1),
        .north0  (bank_n0),
        .north1  (bank_n1)
    );

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        state_nx     = state;
        step_nx      = step;
        feed_nx      = 1'b0;
        job_done_nx  = 1'b0;
        arr_start_nx = '0;
        arr_reset_nx = '0;
`ifdef FEEDER_TIMEOUT_EN
        wd_cnt_nx    = wd_cnt;
        err_nx       = err;
`endif
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx     = ST_CLEAR;
                    arr_reset_nx = ARR_RESET_ALL;
`ifdef FEEDER_TIMEOUT_EN
                    err_nx       = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                state_nx     = ST_STREAM;
                step_nx      = '0;
                feed_nx      = 1'b1;
                arr_start_nx = ARR_START_ALL;
            end
            ST_STREAM: begin
                arr_start_nx = ARR_START_ALL;
                if (step == STEP_W'(K)) begin
                    state_nx  = ST_DRAIN;
`ifdef FEEDER_TIMEOUT_EN
                    wd_cnt_nx = '0;
`endif
                end else begin
                    step_nx = step + STEP_W'(1);
                    feed_nx = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (arr_done) begin
                    state_nx    = ST_DONE;
                    job_done_nx = 1'b1;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT-1)) begin
                    state_nx    = ST_DONE;
                    job_done_nx = 1'b1;
                    err_nx      = 1'b1;
                end else begin
                    wd_cnt_nx    = wd_cnt + CNT_W'(1);
                    arr_start_nx = ARR_START_ALL;
                end
`else
                else begin
                    arr_start_nx = ARR_START_ALL;
                end
`endif
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= '0;
            west0     <= '0;
            west1     <= '0;
            north0    <= '0;
            north1    <= '0;
            arr_start <= '0;
            arr_reset <= '0;
            job_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            west0     <= feed_nx ? bank_w0 : '0;
            west1     <= feed_nx ? bank_w1 : '0;
            north0    <= feed_nx ? bank_n0 : '0;
            north1    <= feed_nx ? bank_n1 : '0;
            arr_start <= arr_start_nx;
            arr_reset <= arr_reset_nx;
            job_done  <= job_done_nx;
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nx;
            err    <= err_nx;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Scoreboard bench for systolic_feeder_2x2 with K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]];
// a small behavioural model of the array's dataflow checks the end-to-end product.
module tb_systolic_feeder_2x2;

    localparam int WIDTH   = 16;
    localparam int K       = 2;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic             load_sel = 1'b0;
    logic [1:0]       load_addr = '0;
    logic [WIDTH-1:0] load_data = '0;
    logic             go = 1'b0;
    logic             busy;
    logic             job_done;
    logic             err;
    logic             arr_done = 1'b0;
    logic [WIDTH-1:0] west0, west1, north0, north1;
    logic [7:0]       arr_start;
    logic [7:0]       arr_reset;

    systolic_feeder_2x2 #(
        .WIDTH   (WIDTH),
        .K       (K),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .go         (go),
        .busy       (busy),
        .job_done   (job_done),
        .err        (err),
        .arr_done   (arr_done),
        .west0      (west0),
        .west1      (west1),
        .north0     (north0),
        .north1     (north1),
        .arr_start  (arr_start),
        .arr_reset  (arr_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [7:0]  rst_v;
        logic [7:0]  start_v;
        logic [63:0] ops;
        logic        jd;
        logic        er;
        bit          chk_prod;
        logic [31:0] p00, p01, p10, p11;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [31:0]      c00 = 0, c01 = 0, c10 = 0, c11 = 0;
    logic [WIDTH-1:0] w0_d = 0, w1_d = 0, n0_d = 0, n1_d = 0;

    function automatic logic [63:0] ops(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic pushRec(input string tag, input logic [7:0] rv, input logic [7:0] sv,
                           input logic [63:0] o, input logic jd, input logic er, input bit chk,
                           input int p00, input int p01, input int p10, input int p11);
        exp_t e;
        e.tag = tag; e.rst_v = rv; e.start_v = sv; e.ops = o; e.jd = jd; e.er = er;
        e.chk_prod = chk; e.p00 = p00; e.p01 = p01; e.p10 = p10; e.p11 = p11;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: models the array's PE dataflow and pops one expected record per busy cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (arr_reset == 8'hFF) begin
                c00 <= 0; c01 <= 0; c10 <= 0; c11 <= 0;
            end else if (arr_start == 8'h0F) begin
                c00 <= c00 + west0 * north0;
                c01 <= c01 + w0_d * north1;
                c10 <= c10 + west1 * n0_d;
                c11 <= c11 + w1_d * n1_d;
            end
            w0_d <= west0; w1_d <= west1; n0_d <= north0; n1_d <= north1;
            if (busy) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_busy: got busy=1 with rst=%h start=%h jd=%b, expected idle",
                             arr_reset, arr_start, job_done);
                end else begin
                    e = expQ.pop_front();
                    if (arr_reset !== e.rst_v || arr_start !== e.start_v ||
                        {west0, west1, north0, north1} !== e.ops ||
                        job_done !== e.jd || err !== e.er) begin
                        miscompares++;
                        $display("[TB] FAIL %s: got rst=%h start=%h ops=%0d,%0d,%0d,%0d jd=%b err=%b, expected rst=%h start=%h ops=%0d,%0d,%0d,%0d jd=%b err=%b",
                                 e.tag, arr_reset, arr_start, west0, west1, north0, north1, job_done, err,
                                 e.rst_v, e.start_v, e.ops[63:48], e.ops[47:32], e.ops[31:16], e.ops[15:0],
                                 e.jd, e.er);
                    end
                    if (e.chk_prod) begin
                        vectors++;
                        if (c00 !== e.p00 || c01 !== e.p01 || c10 !== e.p10 || c11 !== e.p11) begin
                            miscompares++;
                            $display("[TB] FAIL %s_product: got %0d %0d %0d %0d, expected %0d %0d %0d %0d",
                                     e.tag, c00, c01, c10, c11, e.p00, e.p01, e.p10, e.p11);
                        end
                    end
                end
            end
        end
    end

    task automatic loadWord(input logic sel, input int addr, input int data);
        @(negedge clk);
        load_valid = 1'b1; load_sel = sel; load_addr = 2'(addr); load_data = 16'(data);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic loadNominal();
        loadWord(1'b0, 0, 1); loadWord(1'b0, 1, 2); loadWord(1'b0, 2, 3); loadWord(1'b0, 3, 4);
        loadWord(1'b1, 0, 5); loadWord(1'b1, 1, 6); loadWord(1'b1, 2, 7); loadWord(1'b1, 3, 8);
    endtask

    // One complete job: expected per-cycle records are queued before go is pulsed.
    task automatic applyStimulus(input string tag, input logic [63:0] s0, input logic [63:0] s1,
                                 input logic [63:0] s2, input int drain, input bit raiseDone,
                                 input bit chk, input int p00, input int p01, input int p10, input int p11,
                                 input bit errAtDone, input bit goInDrain, input bit doneInStream,
                                 input bit loadInStream, input bit loadWithGo, input int goData);
        pushRec({tag, "_clear"}, 8'hFF, 8'h00, '0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec({tag, "_s0"}, 8'h00, 8'h0F, s0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec({tag, "_s1"}, 8'h00, 8'h0F, s1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec({tag, "_s2"}, 8'h00, 8'h0F, s2, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < drain; i++)
            pushRec($sformatf("%s_drain%0d", tag, i), 8'h00, 8'h0F, '0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec({tag, "_done"}, 8'h00, 8'h00, '0, 1'b1, errAtDone, chk, p00, p01, p10, p11);
        @(negedge clk);
        go = 1'b1;
        if (loadWithGo) begin
            load_valid = 1'b1; load_sel = 1'b0; load_addr = 2'd0; load_data = 16'(goData);
        end
        for (int n = 1; n <= 5 + drain; n++) begin
            @(negedge clk);
            if (n == 1) begin go = 1'b0; load_valid = 1'b0; end
            if (doneInStream && n == 2) arr_done = 1'b1;
            if (doneInStream && n == 3) arr_done = 1'b0;
            if (loadInStream && n == 3) begin
                load_valid = 1'b1; load_sel = 1'b0; load_addr = 2'd0; load_data = 16'd99;
                #1 checkOutput({tag, "_ready_in_stream"}, 32'(load_ready), 32'd0);
            end
            if (loadInStream && n == 4) load_valid = 1'b0;
            if (goInDrain && n == 5) go = 1'b1;
            if (goInDrain && n == 6) go = 1'b0;
            if (raiseDone && n == 4 + drain) arr_done = 1'b1;
            if (raiseDone && n == 5 + drain) arr_done = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_load_ready", 32'(load_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_flags", {30'd0, job_done, err}, 32'd0);
        checkOutput("reset_operands", 32'(west0 | west1 | north0 | north1), 32'd0);
        checkOutput("reset_arr_bus", {16'd0, arr_start, arr_reset}, 32'd0);
        rst = 1'b0;

        loadNominal();
        applyStimulus("nominal", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 1, 1'b1,
                      1, 19, 22, 43, 50, 1'b0, 0, 0, 0, 0, 0);
        applyStimulus("handshake", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 2, 1'b1,
                      1, 19, 22, 43, 50, 1'b0, 0, 1, 1, 0, 0);
        applyStimulus("go_in_drain", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 3, 1'b1,
                      1, 19, 22, 43, 50, 1'b0, 1, 0, 0, 0, 0);
        applyStimulus("load_with_go", ops(9,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 1, 1'b1,
                      1, 59, 70, 43, 50, 1'b0, 0, 0, 0, 1, 9);

        pushRec("midreset_clear", 8'hFF, 8'h00, '0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec("midreset_s0", 8'h00, 8'h0F, ops(9,0,5,0), 1'b0, 1'b0, 0, 0, 0, 0, 0);
        pushRec("midreset_s1", 8'h00, 8'h0F, ops(2,3,7,6), 1'b0, 1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_operands", 32'(west0 | west1 | north0 | north1), 32'd0);
        checkOutput("midreset_arr_bus", {16'd0, arr_start, arr_reset}, 32'd0);
        checkOutput("midreset_flags", {29'd0, busy, job_done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy_after", 32'(busy), 32'd0);
        checkOutput("midreset_ready_after", 32'(load_ready), 32'd1);

        applyStimulus("cleared", ops(0,0,0,0), ops(0,0,0,0), ops(0,0,0,0), 1, 1'b1,
                      1, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);

        loadNominal();
`ifdef FEEDER_TIMEOUT_EN
        applyStimulus("watchdog", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), TIMEOUT, 1'b0,
                      1, 19, 22, 43, 50, 1'b1, 0, 0, 0, 0, 0);
        checkOutput("watchdog_err_sticky", 32'(err), 32'd1);
        applyStimulus("after_watchdog", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 1, 1'b1,
                      1, 19, 22, 43, 50, 1'b0, 0, 0, 0, 0, 0);
        checkOutput("after_watchdog_err", 32'(err), 32'd0);
`else
        applyStimulus("long_drain", ops(1,0,5,0), ops(2,3,7,6), ops(0,4,0,8), 12, 1'b1,
                      1, 19, 22, 43, 50, 1'b0, 0, 0, 0, 0, 0);
        checkOutput("long_drain_err", 32'(err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
